// File: rtl/des_pkg.sv
// DES constants shared by the decryption core: permutation tables,
// S-boxes, key shift schedule, FSM state type and a table-driven permute.
package des_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Entries are 1-based DES bit numbers, bit 1 = MSB; first entry = output MSB.
    localparam logic [63:0][7:0] IP = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam logic [63:0][7:0] FP = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25};

    localparam logic [47:0][7:0] E = '{
        32, 1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
        8,  9,  10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1};

    localparam logic [31:0][7:0] P = '{
        16, 7,  20, 21, 29, 12, 28, 17,  1,  15, 23, 26, 5,  18, 31, 10,
        2,  8,  24, 14, 32, 27, 3,  9,   19, 13, 30, 6,  22, 11, 4,  25};

    localparam logic [55:0][7:0] PC1 = '{
        57, 49, 41, 33, 25, 17, 9,   1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27,  19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29,  21, 13, 5,  28, 20, 12, 4};

    localparam logic [47:0][7:0] PC2 = '{
        14, 17, 11, 24, 1,  5,   3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,   16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    // Encryption-order left shifts; decryption walks this backwards as right rotations.
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    localparam logic [3:0] SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Result is right-aligned in 64 bits; tbl holds out_w entries, right-aligned.
    function automatic logic [63:0] permute(input logic [63:0]  din,
                                            input int           in_w,
                                            input logic [511:0] tbl,
                                            input int           out_w);
        logic [63:0] res;
        res = '0;
        for (int p = 0; p < out_w; p++)
            res[6'(p)] = din[6'(in_w - int'(tbl[9'(p * 8) +: 8]))];
        return res;
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x,
                                          input logic [1:0]  n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_decrypt_core_if.sv
// Valid/ready bundle between a block producer/consumer and the DES
// decryption core.
interface des_decrypt_core_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ctext;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ptext;
    logic        busy;

    modport master (
        output in_valid, ctext, key, out_ready,
        input  in_ready, out_valid, ptext, busy
    );

    modport slave (
        input  in_valid, ctext, key, out_ready,
        output in_ready, out_valid, ptext, busy
    );
endinterface

// File: rtl/des_f.sv
// DES round function f(R,K) = P(S(E(R) ^ K)), purely combinational.
module des_f
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);
    logic [47:0] e_w;
    logic [47:0] x_w;
    logic [31:0] s_w;

    assign e_w = 48'(permute(64'(r_i), 32, 512'(E), 48));
    assign x_w = e_w ^ k_i;

    des_sbox #(.N(1)) sbox1 (.x_i(x_w[47:42]), .y_o(s_w[31:28]));
    des_sbox #(.N(2)) sbox2 (.x_i(x_w[41:36]), .y_o(s_w[27:24]));
    des_sbox #(.N(3)) sbox3 (.x_i(x_w[35:30]), .y_o(s_w[23:20]));
    des_sbox #(.N(4)) sbox4 (.x_i(x_w[29:24]), .y_o(s_w[19:16]));
    des_sbox #(.N(5)) sbox5 (.x_i(x_w[23:18]), .y_o(s_w[15:12]));
    des_sbox #(.N(6)) sbox6 (.x_i(x_w[17:12]), .y_o(s_w[11:8]));
    des_sbox #(.N(7)) sbox7 (.x_i(x_w[11:6]),  .y_o(s_w[7:4]));
    des_sbox #(.N(8)) sbox8 (.x_i(x_w[5:0]),   .y_o(s_w[3:0]));

    assign f_o = 32'(permute(64'(s_w), 32, 512'(P), 32));
endmodule

// File: rtl/des_sbox.sv
// One DES S-box: 6-bit group in, 4-bit value out; row = outer bits,
// column = inner four bits.
module des_sbox
    import des_pkg::*;
#(
    parameter int unsigned N = 1
) (
    input  logic [5:0] x_i,
    output logic [3:0] y_o
);
    assign y_o = SBOX[N-1][{x_i[5], x_i[0], x_i[4:1]}];
endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, subkeys K16..K1
// produced on the fly by rotating the PC-1 halves right.
module des_decrypt_core
    import des_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    des_decrypt_core_if.slave bus
);
    state_e      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic [63:0] ip_w;
    logic [55:0] pc1_w;
    logic [47:0] k_w;
    logic [31:0] f_w;
    logic [1:0]  sh_w;
    logic        accept_w;

    assign accept_w = (state_q == IDLE) && bus.in_valid;
    assign ip_w     = permute(bus.ctext, 64, IP, 64);
    assign pc1_w    = 56'(permute(bus.key, 64, 512'(PC1), 56));
    assign k_w      = 48'(permute(64'({c_q, d_q}), 56, 512'(PC2), 48));
    assign sh_w     = SHIFT[4'd15 - round_q];

    des_f u_f (.r_i(r_q), .k_i(k_w), .f_o(f_w));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)       state_d = RUN;
            RUN:     if (round_q == 4'd15)   state_d = DONE;
            DONE:    if (bus.out_ready)      state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.busy      = (state_q != IDLE);
        bus.out_valid = (state_q == DONE);
        bus.ptext     = permute({r_q, l_q}, 64, FP, 64);
    end

    always_comb begin
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        if (accept_w) begin
            {l_d, r_d} = ip_w;
            {c_d, d_d} = pc1_w;
            round_d    = '0;
        end else if (state_q == RUN) begin
            l_d     = r_q;
            r_d     = l_q ^ f_w;
            c_d     = ror28(c_q, sh_w);
            d_d     = ror28(d_q, sh_w);
            round_d = round_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
        end else begin
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
        end
    end
endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core using known DES test vectors.
module tb_des_decrypt_core;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;
    int   n;

    des_decrypt_core_if bus ();
    des_decrypt_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] ct, input logic [63:0] k);
        bus.ctext    = ct;
        bus.key      = k;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.ctext    = '1;
        bus.key      = '1;
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
        if (bus.out_valid !== 1'b1) cnt = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.ctext     = '0;
        bus.key       = '0;
        #2 rst_n = 1'b0;
        #9;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_ptext",     bus.ptext,          64'h0);
        #1 rst_n = 1'b1;
        step();

        // FIPS example vector, with ignored in_valid pulses mid-run
        bus.out_ready = 1'b1;
        send(64'h85E813540F0AB405, 64'h133457799BBCDFF1);
        chk("t1_busy",     64'(bus.busy),     64'd1);
        chk("t1_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (3) step();
        bus.in_valid = 1'b1;
        bus.ctext    = 64'hDEADBEEFCAFEF00D;
        bus.key      = 64'h0F1E2D3C4B5A6978;
        repeat (2) step();
        bus.in_valid = 1'b0;
        wait_out(n);
        chk("t1_latency", 64'(n + 5), 64'd16);
        chk("t1_ptext",   bus.ptext,  64'h0123456789ABCDEF);
        step();
        chk("t1_ov_drop", 64'(bus.out_valid), 64'd0);
        chk("t1_idle",    64'(bus.in_ready),  64'd1);

        // Backpressure: hold DONE for 10 cycles
        bus.out_ready = 1'b0;
        send(64'h3FA40E8A984D4815, 64'h0123456789ABCDEF);
        wait_out(n);
        chk("t2_latency", 64'(n), 64'd16);
        chk("t2_ptext",   bus.ptext, 64'h4E6F772069732074);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_hold_ptext", bus.ptext,          64'h4E6F772069732074);
            chk("t2_hold_ov",    64'(bus.out_valid), 64'd1);
            chk("t2_hold_ir",    64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        step();
        chk("t2_release", 64'(bus.out_valid), 64'd0);

        // Zero key and parity-only key decrypt identically
        send(64'h8CA64DE9C1B123A7, 64'h0000000000000000);
        wait_out(n);
        chk("t3a_latency", 64'(n), 64'd16);
        chk("t3a_ptext",   bus.ptext, 64'h0);
        step();
        send(64'h8CA64DE9C1B123A7, 64'h0101010101010101);
        wait_out(n);
        chk("t3b_latency", 64'(n), 64'd16);
        chk("t3b_ptext",   bus.ptext, 64'h0);
        step();

        // Back-to-back with in_valid held high
        bus.ctext    = 64'h3FA40E8A984D4815;
        bus.key      = 64'h0123456789ABCDEF;
        bus.in_valid = 1'b1;
        step();
        bus.ctext = 64'h8CA64DE9C1B123A7;
        bus.key   = 64'h0000000000000000;
        wait_out(n);
        chk("t4a_latency", 64'(n), 64'd16);
        chk("t4a_ptext",   bus.ptext, 64'h4E6F772069732074);
        step();
        chk("t4_idle_17",  64'(bus.in_ready), 64'd1);
        step();
        chk("t4_accept_18", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        wait_out(n);
        chk("t4b_latency", 64'(n), 64'd16);
        chk("t4b_ptext",   bus.ptext, 64'h0);
        step();

        // Async reset mid-run, then a fresh block
        send(64'h3FA40E8A984D4815, 64'h0123456789ABCDEF);
        repeat (7) step();
        chk("t5_busy_pre", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ov",    64'(bus.out_valid), 64'd0);
        chk("t5_rst_busy",  64'(bus.busy),      64'd0);
        chk("t5_rst_ir",    64'(bus.in_ready),  64'd1);
        chk("t5_rst_ptext", bus.ptext,          64'h0);
        #2 rst_n = 1'b1;
        step();
        chk("t5_no_resume", 64'(bus.busy), 64'd0);
        send(64'h85E813540F0AB405, 64'h133457799BBCDFF1);
        wait_out(n);
        chk("t5_latency", 64'(n), 64'd16);
        chk("t5_ptext",   bus.ptext, 64'h0123456789ABCDEF);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
